// File: rtl/axi_stream_pipeline_arbiter_pkg.sv
// Shared types and helpers for the pixel-stream arbiter in front of the Sobel pipeline.
package axi_stream_pipeline_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    localparam int BUF_DEPTH = 2;
    localparam int MAX_SRC   = 8;

    // First valid index after 'last', wrapping modulo n (not modulo a power of two).
    function automatic logic [2:0] rr_pick(input logic [MAX_SRC-1:0] valid,
                                           input logic [2:0]         last,
                                           input int                 n);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= MAX_SRC; i++) begin
            idx = (int'(last) + i) % n;
            if (i <= n && !found && valid[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axi_stream_skid_fifo.sv
// Two-entry output buffer; isolates arbitration timing from downstream backpressure.
module axi_stream_skid_fifo
    import axi_stream_pipeline_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic [1:0]   count
);

    logic [BUF_DEPTH-1:0][W-1:0] mem;
    logic                        wr_ptr;
    logic                        rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign do_push = push && (count < 2'(BUF_DEPTH));
    assign do_pop  = pop && (count != 2'd0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_stream_pipeline_arbiter.sv
// Round-robin, packet-locked arbiter sharing one pixel pipeline among NUM_SRC AXI4-Stream sources.
module axi_stream_pipeline_arbiter
    import axi_stream_pipeline_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int DATA_W  = 24,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic [NUM_SRC-1:0]        s_tvalid_i,
    output logic [NUM_SRC-1:0]        s_tready_o,
    input  logic [NUM_SRC-1:0]        s_tlast_i,
    input  logic [NUM_SRC*DATA_W-1:0] s_tdata_i,
    output logic                      m_tvalid_o,
    input  logic                      m_tready_i,
    output logic                      m_tlast_o,
    output logic [DATA_W-1:0]         m_tdata_o,
    output logic [ID_W-1:0]           m_tid_o,
    output logic [NUM_SRC-1:0]        grant_o,
    output logic                      busy_o
);

    localparam int PW = ID_W + 1 + DATA_W;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    arb_state_t           state;
    logic [ID_W-1:0]      gidx;
    logic [ID_W-1:0]      last_grant;
    logic [ID_W-1:0]      pick;
    logic [MAX_SRC-1:0]   valid_ext;
    logic [1:0]           buf_cnt;
    logic                 room;
    logic                 push;
    logic                 pop;
    beat_t                wr_beat;
    beat_t                rd_beat;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_SRC-1:0]   = s_tvalid_i;
        pick = ID_W'(rr_pick(valid_ext, 3'(last_grant), NUM_SRC));
    end

    // Ready depends only on the lock and buffer space, never on m_tready_i.
    assign room       = buf_cnt < 2'(BUF_DEPTH);
    assign s_tready_o = (state == LOCKED && room) ? grant_o : '0;
    assign push       = |(s_tvalid_i & s_tready_o);

    always_comb begin
        wr_beat      = '0;
        wr_beat.id   = gidx;
        wr_beat.last = s_tlast_i[gidx];
        wr_beat.data = s_tdata_i[gidx*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            gidx       <= '0;
            last_grant <= ID_W'(NUM_SRC - 1);
            grant_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_i && |s_tvalid_i) begin
                        gidx    <= pick;
                        grant_o <= NUM_SRC'(1) << pick;
                        state   <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (push && s_tlast_i[gidx]) begin
                        state      <= IDLE;
                        last_grant <= gidx;
                        grant_o    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_tvalid_o = (buf_cnt != 2'd0);
    assign pop        = m_tvalid_o & m_tready_i;

    axi_stream_skid_fifo #(.W(PW)) u_buf (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .wdata (wr_beat),
        .pop   (pop),
        .rdata (rd_beat),
        .count (buf_cnt)
    );

    assign m_tdata_o = rd_beat.data;
    assign m_tlast_o = rd_beat.last;
    assign m_tid_o   = rd_beat.id;
    assign busy_o    = (state == LOCKED) || m_tvalid_o;

endmodule

// File: tb/tb_axi_stream_pipeline_arbiter.sv
// Directed bench for the packet-locked round-robin arbiter, four sources.
module tb_axi_stream_pipeline_arbiter;

    localparam int NS = 4;
    localparam int DW = 24;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             en_i;
    logic [NS-1:0]    s_tvalid_i;
    logic [NS-1:0]    s_tready_o;
    logic [NS-1:0]    s_tlast_i;
    logic [NS*DW-1:0] s_tdata_i;
    logic             m_tvalid_o;
    logic             m_tready_i;
    logic             m_tlast_o;
    logic [DW-1:0]    m_tdata_o;
    logic [IW-1:0]    m_tid_o;
    logic [NS-1:0]    grant_o;
    logic             busy_o;

    axi_stream_pipeline_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .ID_W(IW)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en_i),
        .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o), .s_tlast_i(s_tlast_i), .s_tdata_i(s_tdata_i),
        .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .m_tlast_o(m_tlast_o), .m_tdata_o(m_tdata_o),
        .m_tid_o(m_tid_o), .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [24:0] smem [NS][64];
    int          shead [NS];
    int          stail [NS];
    int          src_pops [NS];
    logic        src_en [NS];
    logic [26:0] oq [$];
    int          ot [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NS; k++) begin
            if (src_en[k] && shead[k] != stail[k]) begin
                s_tvalid_i[k]         = 1'b1;
                s_tlast_i[k]          = smem[k][shead[k]][24];
                s_tdata_i[k*DW +: DW] = smem[k][shead[k]][23:0];
            end else begin
                s_tvalid_i[k]         = 1'b0;
                s_tlast_i[k]          = 1'b0;
                s_tdata_i[k*DW +: DW] = '0;
            end
        end
    endtask

    // Handshakes are sampled at the negedge; inputs change 1 time unit after posedge.
    task automatic step();
        logic [NS-1:0] shs;
        shs = s_tvalid_i & s_tready_o;
        if (m_tvalid_o && m_tready_i) begin
            oq.push_back({m_tid_o, m_tlast_o, m_tdata_o});
            ot.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NS; k++)
            if (shs[k]) begin
                shead[k]++;
                src_pops[k]++;
            end
        drive();
        @(negedge clk);
    endtask

    task automatic load(input int k, input logic [23:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            smem[k][stail[k]] = {(i == n - 1), base + 24'(i)};
            stail[k]++;
        end
    endtask

    task automatic clear_src();
        for (int k = 0; k < NS; k++) begin
            shead[k] = 0; stail[k] = 0; src_pops[k] = 0; src_en[k] = 1'b1;
        end
        oq.delete();
        ot.delete();
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_src();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int n);
        int k;
        k = 0;
        while (oq.size() < n && k < 200) begin
            step();
            k++;
        end
        chk(tag, 32'(oq.size()), 32'(n));
    endtask

    task automatic chk_beat(input string tag, input logic [IW-1:0] id, input logic last, input logic [23:0] data);
        logic [26:0] b;
        chk({tag, "_avail"}, 32'(oq.size() != 0), 32'd1);
        if (oq.size() != 0) begin
            b = oq.pop_front();
            chk(tag, 32'(b), 32'({id, last, data}));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] hold;
        int          k;
        rst = 1'b1; en_i = 1'b1; m_tready_i = 1'b1;
        s_tvalid_i = '0; s_tlast_i = '0; s_tdata_i = '0;
        clear_src();
        @(negedge clk);

        // Reset state
        chk("rst_mvalid", 32'(m_tvalid_o), 0);
        chk("rst_sready", 32'(s_tready_o), 0);
        chk("rst_grant",  32'(grant_o), 0);
        chk("rst_busy",   32'(busy_o), 0);
        chk("rst_mfields", 32'({m_tlast_o, m_tid_o, m_tdata_o}), 0);

        // T1: single source, 4-beat packet
        rst = 1'b0;
        load(0, 24'h000001, 4);
        step();
        chk("t1_pre_grant", 32'(grant_o), 0);
        step();
        chk("t1_grant", 32'(grant_o), 32'h1);
        wait_out("t1_count", 4);
        chk("t1_consec", 32'(ot[3] - ot[0]), 3);
        chk_beat("t1_b0", 0, 0, 24'h000001);
        chk_beat("t1_b1", 0, 0, 24'h000002);
        chk_beat("t1_b2", 0, 0, 24'h000003);
        chk_beat("t1_b3", 0, 1, 24'h000004);
        chk("t1_busy_end", 32'(busy_o), 0);
        chk("t1_grant_end", 32'(grant_o), 0);

        // T2: two competing sources, two 3-beat packets each
        do_reset();
        load(0, 24'h10, 3); load(0, 24'h13, 3);
        load(1, 24'h20, 3); load(1, 24'h23, 3);
        wait_out("t2_count", 12);
        chk("t2_in_pkt", 32'(ot[2] - ot[0]), 2);
        chk("t2_gap", 32'(ot[3] - ot[2]), 2);
        chk_beat("t2_b0",  0, 0, 24'h10); chk_beat("t2_b1",  0, 0, 24'h11); chk_beat("t2_b2",  0, 1, 24'h12);
        chk_beat("t2_b3",  1, 0, 24'h20); chk_beat("t2_b4",  1, 0, 24'h21); chk_beat("t2_b5",  1, 1, 24'h22);
        chk_beat("t2_b6",  0, 0, 24'h13); chk_beat("t2_b7",  0, 0, 24'h14); chk_beat("t2_b8",  0, 1, 24'h15);
        chk_beat("t2_b9",  1, 0, 24'h23); chk_beat("t2_b10", 1, 0, 24'h24); chk_beat("t2_b11", 1, 1, 24'h25);
        step(); step();

        // T3: src1 requests mid-packet, no preemption
        src_en[1] = 1'b0;
        load(0, 24'h30, 4);
        load(1, 24'h40, 1);
        step(); step();
        chk("t3_grant0", 32'(grant_o), 32'h1);
        src_en[1] = 1'b1;
        k = 0;
        while (grant_o == 4'b0001 && k < 20) begin
            chk("t3_rdy1_low", 32'(s_tready_o[1]), 0);
            step();
            k++;
        end
        chk("t3_bubble", 32'(grant_o), 0);
        step();
        chk("t3_grant1", 32'(grant_o), 32'h2);
        wait_out("t3_count", 5);
        chk_beat("t3_b0", 0, 0, 24'h30); chk_beat("t3_b1", 0, 0, 24'h31);
        chk_beat("t3_b2", 0, 0, 24'h32); chk_beat("t3_b3", 0, 1, 24'h33);
        chk_beat("t3_b4", 1, 1, 24'h40);
        step(); step();

        // T4: 5 cycles of downstream backpressure in an 8-beat packet
        load(0, 24'h50, 8);
        step(); step(); step(); step();
        m_tready_i = 1'b0;
        hold = m_tdata_o;
        chk("t4_head_pre", 32'(hold), 32'h51);
        repeat (5) step();
        chk("t4_full_valid", 32'(m_tvalid_o), 1);
        chk("t4_full_rdy",   32'(s_tready_o), 0);
        chk("t4_head_hold",  32'(m_tdata_o), 32'h51);
        chk("t4_busy",       32'(busy_o), 1);
        m_tready_i = 1'b1;
        wait_out("t4_count", 8);
        for (int i = 0; i < 8; i++)
            chk_beat($sformatf("t4_b%0d", i), 0, (i == 7), 24'h50 + 24'(i));
        step(); step();

        // T5: enable gating with src2
        en_i = 1'b0;
        load(2, 24'h60, 2);
        load(2, 24'h62, 1);
        repeat (3) begin
            step();
            chk("t5_no_grant", 32'(grant_o), 0);
        end
        en_i = 1'b1;
        step();
        chk("t5_grant2", 32'(grant_o), 32'h4);
        en_i = 1'b0;
        wait_out("t5_count", 2);
        repeat (4) step();
        chk("t5_idle_grant", 32'(grant_o), 0);
        chk("t5_idle_busy", 32'(busy_o), 0);
        chk("t5_left", 32'(stail[2] - shead[2]), 1);
        chk_beat("t5_b0", 2, 0, 24'h60);
        chk_beat("t5_b1", 2, 1, 24'h61);
        stail[2] = shead[2];
        en_i = 1'b1;
        step();

        // T6: reset mid-packet, then src0 wins first
        src_pops[0] = 0;
        load(0, 24'h70, 5);
        load(1, 24'h80, 1);
        k = 0;
        while (src_pops[0] < 2 && k < 20) begin
            step();
            k++;
        end
        rst = 1'b1;
        #1;
        chk("t6_rst_ctrl", 32'({m_tvalid_o, m_tlast_o, m_tid_o, grant_o, s_tready_o, busy_o}), 0);
        chk("t6_rst_data", 32'(m_tdata_o), 0);
        clear_src();
        load(0, 24'h70, 5);
        load(1, 24'h80, 1);
        step(); step();
        rst = 1'b0;
        step();
        chk("t6_first_grant", 32'(grant_o), 32'h1);
        wait_out("t6_count", 6);
        for (int i = 0; i < 5; i++)
            chk_beat($sformatf("t6_b%0d", i), 0, (i == 4), 24'h70 + 24'(i));
        chk_beat("t6_b5", 1, 1, 24'h80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
